// File: rtl/id_stage_if.sv
// IF/ID boundary bundle: IFU-side request/control inputs and registered decode outputs.
interface id_stage_if;
    logic [31:0] instruction;
    logic        if_valid;
    logic        stall_in;
    logic        flush;
    logic        hazard_stall;
    logic        id_valid;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic [25:0] addr26;
    logic        reg_dst;
    logic        alu_src;
    logic        mem_to_reg;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        is_branch;
    logic        is_jump;
    logic        ext_op;
    logic [2:0]  alu_ctrl;
    logic        illegal_instr;

    modport master (
        output instruction, if_valid, stall_in, flush,
        input  hazard_stall, id_valid, rs, rt, rd, shamt, funct, imm16, addr26,
        input  reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write,
        input  is_branch, is_jump, ext_op, alu_ctrl, illegal_instr
    );

    modport slave (
        input  instruction, if_valid, stall_in, flush,
        output hazard_stall, id_valid, rs, rt, rd, shamt, funct, imm16, addr26,
        output reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write,
        output is_branch, is_jump, ext_op, alu_ctrl, illegal_instr
    );
endinterface

// File: rtl/id_stage.sv
// MIPS-subset instruction decode stage: IF/ID pipeline register with control
// decode, hold/flush handling and load-use hazard detection.
module id_stage (
    input  logic      clk,
    input  logic      reset,
    id_stage_if.slave bus
);
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    typedef struct packed {
        logic        valid;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [15:0] imm16;
        logic [25:0] addr26;
        logic        reg_dst;
        logic        alu_src;
        logic        mem_to_reg;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        is_branch;
        logic        is_jump;
        logic        ext_op;
        logic [2:0]  alu_ctrl;
        logic        illegal;
    } id_regs_t;

    id_regs_t   regs_q;
    id_regs_t   dec_c;
    logic [5:0] opcode_c;
    logic       legal_op_c;
    logic       uses_rt_c;
    logic       hazard_c;

    assign opcode_c = bus.instruction[31:26];

    // Combinational decode of the incoming instruction into the next register image
    always_comb begin
        dec_c        = '0;
        dec_c.valid  = 1'b1;
        dec_c.rs     = bus.instruction[25:21];
        dec_c.rt     = bus.instruction[20:16];
        dec_c.rd     = bus.instruction[15:11];
        dec_c.shamt  = bus.instruction[10:6];
        dec_c.funct  = bus.instruction[5:0];
        dec_c.imm16  = bus.instruction[15:0];
        dec_c.addr26 = bus.instruction[25:0];
        case (opcode_c)
            OP_RTYPE: begin
                dec_c.reg_dst   = 1'b1;
                dec_c.reg_write = 1'b1;
                case (bus.instruction[5:0])
                    FN_ADD:  dec_c.alu_ctrl = ALU_ADD;
                    FN_SUB:  dec_c.alu_ctrl = ALU_SUB;
                    FN_AND:  dec_c.alu_ctrl = ALU_AND;
                    FN_OR:   dec_c.alu_ctrl = ALU_OR;
                    FN_SLT:  dec_c.alu_ctrl = ALU_SLT;
                    default: begin
                        dec_c.reg_dst   = 1'b0;
                        dec_c.reg_write = 1'b0;
                        dec_c.illegal   = 1'b1;
                    end
                endcase
            end
            OP_LW: begin
                dec_c.alu_src    = 1'b1;
                dec_c.mem_to_reg = 1'b1;
                dec_c.reg_write  = 1'b1;
                dec_c.mem_read   = 1'b1;
                dec_c.ext_op     = 1'b1;
                dec_c.alu_ctrl   = ALU_ADD;
            end
            OP_SW: begin
                dec_c.alu_src   = 1'b1;
                dec_c.mem_write = 1'b1;
                dec_c.ext_op    = 1'b1;
                dec_c.alu_ctrl  = ALU_ADD;
            end
            OP_BEQ: begin
                dec_c.is_branch = 1'b1;
                dec_c.ext_op    = 1'b1;
                dec_c.alu_ctrl  = ALU_SUB;
            end
            OP_ADDI: begin
                dec_c.alu_src   = 1'b1;
                dec_c.reg_write = 1'b1;
                dec_c.ext_op    = 1'b1;
                dec_c.alu_ctrl  = ALU_ADD;
            end
            OP_ORI: begin
                dec_c.alu_src   = 1'b1;
                dec_c.reg_write = 1'b1;
                dec_c.alu_ctrl  = ALU_OR;
            end
            OP_J:    dec_c.is_jump = 1'b1;
            default: dec_c.illegal = 1'b1;
        endcase
    end

    // Opcode legality and whether the incoming instruction reads its rt field
    always_comb begin
        legal_op_c = 1'b0;
        uses_rt_c  = 1'b0;
        case (opcode_c)
            OP_RTYPE, OP_BEQ, OP_SW: begin
                legal_op_c = 1'b1;
                uses_rt_c  = 1'b1;
            end
            OP_LW, OP_ADDI, OP_ORI, OP_J: legal_op_c = 1'b1;
            default: ;
        endcase
    end

    // Load-use: the registered lw writes a register the incoming instruction reads
    always_comb begin
        hazard_c = 1'b0;
        if (regs_q.valid && regs_q.mem_read && (regs_q.rt != 5'd0) &&
            bus.if_valid && legal_op_c && !bus.flush && !bus.stall_in) begin
            hazard_c = (bus.instruction[25:21] == regs_q.rt) ||
                       (uses_rt_c && (bus.instruction[20:16] == regs_q.rt));
        end
    end

    always_ff @(posedge clk) begin
        if (reset)              regs_q <= '0;
        else if (bus.flush)     regs_q <= '0;
        else if (bus.stall_in)  regs_q <= regs_q;
        else if (hazard_c)      regs_q <= '0;
        else if (bus.if_valid)  regs_q <= dec_c;
        else                    regs_q <= '0;
    end

    assign bus.hazard_stall  = hazard_c;
    assign bus.id_valid      = regs_q.valid;
    assign bus.rs            = regs_q.rs;
    assign bus.rt            = regs_q.rt;
    assign bus.rd            = regs_q.rd;
    assign bus.shamt         = regs_q.shamt;
    assign bus.funct         = regs_q.funct;
    assign bus.imm16         = regs_q.imm16;
    assign bus.addr26        = regs_q.addr26;
    assign bus.reg_dst       = regs_q.reg_dst;
    assign bus.alu_src       = regs_q.alu_src;
    assign bus.mem_to_reg    = regs_q.mem_to_reg;
    assign bus.reg_write     = regs_q.reg_write;
    assign bus.mem_read      = regs_q.mem_read;
    assign bus.mem_write     = regs_q.mem_write;
    assign bus.is_branch     = regs_q.is_branch;
    assign bus.is_jump       = regs_q.is_jump;
    assign bus.ext_op        = regs_q.ext_op;
    assign bus.alu_ctrl      = regs_q.alu_ctrl;
    assign bus.illegal_instr = regs_q.illegal;
endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: directed test-plan sequence followed by
// randomized traffic, checked against a mnemonic-level reference model.
module tb_id_stage;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    id_stage_if bus ();
    id_stage dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct packed {
        logic        valid;
        logic [4:0]  rs, rt, rd, shamt;
        logic [5:0]  funct;
        logic [15:0] imm16;
        logic [25:0] addr26;
        logic        reg_dst, alu_src, mem_to_reg, reg_write, mem_read, mem_write;
        logic        is_branch, is_jump, ext_op;
        logic [2:0]  alu_ctrl;
        logic        illegal;
    } rec_t;

    typedef struct packed {
        rec_t st;
        logic hz;
    } exp_t;

    exp_t sbq[$];
    rec_t m;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_push   = 0;
    int   n_pop    = 0;

    function automatic string mnem(logic [31:0] i);
        logic [5:0] op;
        logic [5:0] fn;
        op = i[31:26];
        fn = i[5:0];
        case (op)
            6'h00: case (fn)
                       6'h20: return "add";
                       6'h22: return "sub";
                       6'h24: return "and";
                       6'h25: return "or";
                       6'h2a: return "slt";
                       default: return "illr";
                   endcase
            6'h23: return "lw";
            6'h2b: return "sw";
            6'h04: return "beq";
            6'h08: return "addi";
            6'h0d: return "ori";
            6'h02: return "j";
            default: return "ill";
        endcase
    endfunction

    function automatic rec_t decode(logic [31:0] i);
        rec_t  r;
        string mn;
        logic  alu_r;
        mn    = mnem(i);
        alu_r = (mn == "add") || (mn == "sub") || (mn == "and") || (mn == "or") || (mn == "slt");
        r = '0;
        r.valid      = 1'b1;
        r.rs         = i[25:21];
        r.rt         = i[20:16];
        r.rd         = i[15:11];
        r.shamt      = i[10:6];
        r.funct      = i[5:0];
        r.imm16      = i[15:0];
        r.addr26     = i[25:0];
        r.reg_dst    = alu_r;
        r.reg_write  = alu_r || (mn == "lw") || (mn == "addi") || (mn == "ori");
        r.alu_src    = (mn == "lw") || (mn == "sw") || (mn == "addi") || (mn == "ori");
        r.mem_to_reg = (mn == "lw");
        r.mem_read   = (mn == "lw");
        r.mem_write  = (mn == "sw");
        r.is_branch  = (mn == "beq");
        r.is_jump    = (mn == "j");
        r.ext_op     = (mn == "lw") || (mn == "sw") || (mn == "beq") || (mn == "addi");
        if (mn == "and")                                               r.alu_ctrl = 3'd0;
        else if (mn == "or" || mn == "ori")                            r.alu_ctrl = 3'd1;
        else if (mn == "add" || mn == "lw" || mn == "sw" || mn == "addi") r.alu_ctrl = 3'd2;
        else if (mn == "sub" || mn == "beq")                           r.alu_ctrl = 3'd6;
        else if (mn == "slt")                                          r.alu_ctrl = 3'd7;
        else                                                           r.alu_ctrl = 3'd0;
        r.illegal    = (mn == "ill") || (mn == "illr");
        return r;
    endfunction

    function automatic logic hazard(rec_t s, logic [31:0] i, logic v, logic st, logic fl);
        string mn;
        logic  reads_rt;
        mn       = mnem(i);
        reads_rt = (i[31:26] == 6'h00) || (mn == "beq") || (mn == "sw");
        if (fl || st || !v || !s.valid || !s.mem_read || s.rt == 5'd0 || mn == "ill") return 1'b0;
        return (i[25:21] == s.rt) || (reads_rt && i[20:16] == s.rt);
    endfunction

    function automatic rec_t next_state(rec_t s, logic rst, logic [31:0] i, logic v,
                                        logic st, logic fl, logic hz);
        if (rst)     return '0;
        if (fl)      return '0;
        if (st)      return s;
        if (hz)      return '0;
        if (v)       return decode(i);
        return '0;
    endfunction

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    logic last_hz;

    // One clock: drive inputs, record expectation, take the edge, advance the model
    task automatic cycle(logic rst, logic [31:0] ins, logic v, logic st, logic fl);
        logic hz;
        reset           = rst;
        bus.instruction = ins;
        bus.if_valid    = v;
        bus.stall_in    = st;
        bus.flush       = fl;
        hz = hazard(m, ins, v, st, fl);
        sbq.push_back({m, hz});
        n_push++;
        last_hz = hz;
        @(posedge clk);
        #1;
        m = next_state(m, rst, ins, v, st, fl, hz);
    endtask

    // Monitor: compare the DUT's presented state and hazard against the queue head
    initial begin
        exp_t e;
        rec_t got;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                n_pop++;
                got = {bus.id_valid, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funct,
                       bus.imm16, bus.addr26, bus.reg_dst, bus.alu_src, bus.mem_to_reg,
                       bus.reg_write, bus.mem_read, bus.mem_write, bus.is_branch,
                       bus.is_jump, bus.ext_op, bus.alu_ctrl, bus.illegal_instr};
                n_checks++;
                if (got !== e.st) begin
                    n_fail++;
                    $display("FAIL state t=%0t got=%h exp=%h", $time, got, e.st);
                end
                n_checks++;
                if (bus.hazard_stall !== e.hz) begin
                    n_fail++;
                    $display("FAIL hazard_stall t=%0t got=%b exp=%b", $time, bus.hazard_stall, e.hz);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] rand_instr();
        logic [4:0]  a, b, c;
        logic [15:0] imm;
        logic [5:0]  fns [5];
        int          k;
        fns[0] = 6'h20; fns[1] = 6'h22; fns[2] = 6'h24; fns[3] = 6'h25; fns[4] = 6'h2a;
        a   = 5'($urandom_range(0, 3));
        b   = 5'($urandom_range(0, 3));
        c   = 5'($urandom_range(0, 31));
        imm = 16'($urandom);
        k   = int'($urandom_range(0, 9));
        case (k)
            0, 1: return {6'h23, a, b, imm};
            2:    return {6'h00, a, b, c, 5'($urandom), fns[$urandom_range(0, 4)]};
            3:    return {6'h2b, a, b, imm};
            4:    return {6'h04, a, b, imm};
            5:    return {6'h08, a, b, imm};
            6:    return {6'h0d, a, b, imm};
            7:    return {6'h02, 26'($urandom)};
            8:    return {6'h00, a, b, c, 5'd0, 6'($urandom_range(0, 31))};
            default: return {6'($urandom_range(48, 63)), a, b, imm};
        endcase
    endfunction

    initial begin
        logic [31:0] ins;
        logic        v, st, fl, rst;
        reset = 1'b1;
        bus.instruction = 32'h00221820;
        bus.if_valid = 1'b1;
        bus.stall_in = 1'b0;
        bus.flush = 1'b0;
        @(posedge clk);
        #1;
        m = '0;

        cycle(1'b1, 32'h00221820, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 32'h00221820, 1'b1, 1'b0, 1'b0);
        chk("add_rd", 32'(bus.rd), 32'd3);
        chk("add_alu", 32'(bus.alu_ctrl), 32'd2);
        cycle(1'b0, 32'h8C220008, 1'b1, 1'b0, 1'b0);
        chk("lw_imm", 32'(bus.imm16), 32'h8);
        chk("lw_mem_read", 32'(bus.mem_read), 32'd1);
        cycle(1'b0, 32'h00452020, 1'b1, 1'b0, 1'b0);
        chk("hz_bubble", 32'(bus.id_valid), 32'd0);
        cycle(1'b0, 32'h00452020, 1'b1, 1'b0, 1'b0);
        chk("add2_rd", 32'(bus.rd), 32'd4);
        cycle(1'b0, 32'h8C220008, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 32'h340400F0, 1'b1, 1'b0, 1'b0);
        chk("ori_alu", 32'(bus.alu_ctrl), 32'd1);
        cycle(1'b0, 32'h1022FFFE, 1'b1, 1'b0, 1'b0);
        chk("beq_imm", 32'(bus.imm16), 32'hFFFE);
        cycle(1'b0, 32'h08000002, 1'b1, 1'b0, 1'b0);
        chk("j_addr", 32'(bus.addr26), 32'h2);
        cycle(1'b0, 32'h00221820, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h08000002, 1'b1, 1'b1, 1'b0);
        chk("stall_hold_rd", 32'(bus.rd), 32'd3);
        cycle(1'b0, 32'h08000002, 1'b1, 1'b1, 1'b1);
        chk("flush_bubble", 32'(bus.id_valid), 32'd0);
        cycle(1'b0, 32'hFC000000, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 32'h0000003F, 1'b1, 1'b0, 1'b0);
        chk("illr_flag", 32'(bus.illegal_instr), 32'd1);
        cycle(1'b0, 32'h00000000, 1'b0, 1'b0, 1'b0);
        // Reset arriving while a load-use hazard is being signalled
        cycle(1'b0, 32'h8C220008, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 32'h00452020, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 32'h00452020, 1'b1, 1'b0, 1'b0);

        ins = 32'h0;
        for (int n = 0; n < 3000; n++) begin
            if (!last_hz) ins = rand_instr();
            v   = last_hz ? 1'b1 : ($urandom_range(0, 7) != 0);
            st  = ($urandom_range(0, 9) == 0);
            fl  = ($urandom_range(0, 15) == 0);
            rst = ($urandom_range(0, 199) == 0);
            cycle(rst, ins, v, st, fl);
        end

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(n_pop), 32'(n_push));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
